// File: rtl/apb_uart_tx_completer.sv
// ---------------------------------------------------------------------------
// apb_uart_tx_completer
//
// APB3 completer that owns a small register map and turns CPU writes into an
// 8N1 UART stream on tx. Bytes written to TXDATA are queued in a TX FIFO and
// serialised LSB first: one start bit (0), eight data bits, one stop bit (1).
// Each bit lasts div_q+1 PCLK cycles. div_q is a copy of BAUDDIV taken when
// the frame is loaded.
//
// Register map (byte offsets, PADDR[3:2] decoded):
//   0x0 TXDATA  W: push PWDATA[7:0]           R: 0
//   0x4 STATUS  R: [0]tx_full [1]fifo_empty [2]tx_busy [11:8]fifo_count
//   0x8 BAUDDIV RW [15:0]
//   0xC CTRL    RW [0]en (0 holds the FIFO; a running frame still completes)
//
// Ports:
//   PCLK, PRESETn          clock / synchronous active-low reset
//   PSEL, PENABLE, PWRITE  APB control
//   PADDR, PWDATA          APB address / write data
//   PRDATA, PREADY,        APB response. Combinational, zero wait states,
//   PSLVERR                all zero outside the access phase.
//   tx                     UART serial output, idle high
//   tx_full                FIFO full flag
//   tx_busy                frame in progress
// ---------------------------------------------------------------------------
module apb_uart_tx_completer #(
    parameter int          ADDR_W      = 5,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              tx,
    output logic              tx_full,
    output logic              tx_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // APB decode
    logic        access_s;
    logic        addr_err_s;
    logic [1:0]  reg_sel_s;
    logic        push_s;
    logic        cfg_wr_s;
    logic [31:0] rd_mux_s;

    // configuration registers
    logic [15:0] baud_r;
    logic        en_r;

    // FIFO
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_n_s;
    logic             full_s;
    logic             empty_s;
    logic [7:0]       head_s;
    logic [3:0]       count4_s;

    // TX engine
    tx_state_t   state_r, state_n_s;
    logic        tx_r, tx_n_s;
    logic        busy_r;
    logic [15:0] cnt_r, cnt_n_s;
    logic [15:0] div_r, div_n_s;
    logic [7:0]  shift_r, shift_n_s;
    logic [2:0]  bit_r, bit_n_s;
    logic        bit_done_s;
    logic        frame_ready_s;
    logic        pop_s;

    // Inputs the register map never looks at.
    logic        input_unused_s;

    assign input_unused_s = ^{PWDATA[31:16], PADDR[1:0]};

    assign access_s   = PSEL & PENABLE;
    assign addr_err_s = |PADDR[ADDR_W-1:4];
    assign reg_sel_s  = PADDR[3:2];

    assign full_s   = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s  = (count_r == {CNT_W{1'b0}});
    assign head_s   = mem_r[rd_ptr_r];
    assign count4_s = 4'(count_r);

    // The full test uses the pre-edge count, so a write in the same cycle as
    // a pop from a full FIFO still errors and the byte is dropped.
    assign PREADY   = access_s;
    assign PSLVERR  = access_s & (addr_err_s | (PWRITE & (reg_sel_s == 2'd0) & full_s));
    assign PRDATA   = (access_s & ~PWRITE & ~PSLVERR) ? rd_mux_s : 32'd0;

    assign push_s   = access_s & PWRITE & ~PSLVERR & (reg_sel_s == 2'd0);
    assign cfg_wr_s = access_s & PWRITE & ~PSLVERR;

    assign frame_ready_s = en_r & ~empty_s;
    assign bit_done_s    = (cnt_r == 16'd0);

    assign tx      = tx_r;
    assign tx_busy = busy_r;
    assign tx_full = full_s;

    // Read data multiplexer
    always_comb begin
        rd_mux_s = 32'd0;
        case (reg_sel_s)
            2'd0:    rd_mux_s = 32'd0;
            2'd1:    rd_mux_s = {20'd0, count4_s, 5'd0, busy_r, empty_s, full_s};
            2'd2:    rd_mux_s = {16'd0, baud_r};
            2'd3:    rd_mux_s = {31'd0, en_r};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Configuration registers (BAUDDIV, CTRL)
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            baud_r <= DEFAULT_DIV;
            en_r   <= 1'b1;
        end else begin
            if (cfg_wr_s && (reg_sel_s == 2'd2)) begin
                baud_r <= PWDATA[15:0];
            end
            if (cfg_wr_s && (reg_sel_s == 2'd3)) begin
                en_r <= PWDATA[0];
            end
        end
    end

    // FIFO occupancy next value
    always_comb begin
        count_n_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_n_s = count_r + CNT_W'(1);
            2'b01:   count_n_s = count_r - CNT_W'(1);
            default: count_n_s = count_r;
        endcase
    end

    // FIFO storage and pointers
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= PWDATA[7:0];
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_n_s;
        end
    end

    // TX engine next-state and datapath
    always_comb begin
        state_n_s = state_r;
        tx_n_s    = tx_r;
        cnt_n_s   = cnt_r;
        div_n_s   = div_r;
        shift_n_s = shift_r;
        bit_n_s   = bit_r;
        pop_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tx_n_s = 1'b1;
                pop_s  = frame_ready_s;
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_n_s = ST_DATA;
                    tx_n_s    = shift_r[0];
                    cnt_n_s   = div_r;
                    bit_n_s   = 3'd0;
                end else begin
                    cnt_n_s = cnt_r - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    cnt_n_s = div_r;
                    if (bit_r == 3'd7) begin
                        state_n_s = ST_STOP;
                        tx_n_s    = 1'b1;
                    end else begin
                        bit_n_s   = bit_r + 3'd1;
                        shift_n_s = {1'b0, shift_r[7:1]};
                        tx_n_s    = shift_r[1];
                    end
                end else begin
                    cnt_n_s = cnt_r - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    // Chain straight into the next start bit when a byte is
                    // waiting, so back-to-back frames have no idle gap.
                    state_n_s = ST_IDLE;
                    tx_n_s    = 1'b1;
                    pop_s     = frame_ready_s;
                end else begin
                    cnt_n_s = cnt_r - 16'd1;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                tx_n_s    = 1'b1;
            end
        endcase

        // Frame load: BAUDDIV is captured here, so later writes only affect
        // the next frame.
        if (pop_s) begin
            state_n_s = ST_START;
            tx_n_s    = 1'b0;
            cnt_n_s   = baud_r;
            div_n_s   = baud_r;
            shift_n_s = head_s;
            bit_n_s   = 3'd0;
        end else begin
            div_n_s = div_r;
        end
    end

    // TX engine registers
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_r <= ST_IDLE;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            cnt_r   <= 16'd0;
            div_r   <= 16'd0;
            shift_r <= 8'd0;
            bit_r   <= 3'd0;
        end else begin
            state_r <= state_n_s;
            tx_r    <= tx_n_s;
            busy_r  <= (state_n_s != ST_IDLE);
            cnt_r   <= cnt_n_s;
            div_r   <= div_n_s;
            shift_r <= shift_n_s;
            bit_r   <= bit_n_s;
        end
    end

endmodule

// File: tb/tb_apb_uart_tx_completer.sv
// ---------------------------------------------------------------------------
// Testbench for apb_uart_tx_completer. A frame-level reference model (a byte
// queue plus "which bit of the current frame are we in" arithmetic) predicts
// tx, tx_busy, tx_full and every APB response. Directed scenarios are
// followed by randomized APB traffic.
// ---------------------------------------------------------------------------
module tb_apb_uart_tx_completer;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 8;

    logic              PCLK;
    logic              PRESETn;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic              tx;
    logic              tx_full;
    logic              tx_busy;

    int checks_r = 0;
    int errors_r = 0;

    // reference model state
    bit [7:0]  m_q[$];
    bit        m_en   = 1'b1;
    bit [15:0] m_baud = 16'd867;
    bit        m_busy = 1'b0;
    bit [9:0]  m_bits = 10'h3FF;
    int        m_div  = 0;
    int        m_t    = 0;

    apb_uart_tx_completer #(
        .ADDR_W      (ADDR_W),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd867)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .tx      (tx),
        .tx_full (tx_full),
        .tx_busy (tx_busy)
    );

    initial PCLK = 1'b0;
    // clock
    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_tx();
        if (m_busy) return m_bits[m_t / (m_div + 1)];
        return 1'b1;
    endfunction

    function automatic bit exp_err(input bit wr, input logic [ADDR_W-1:0] a);
        return a[4] || (wr && (a[3:2] == 2'd0) && (m_q.size() == DEPTH));
    endfunction

    function automatic logic [31:0] exp_rd(input bit wr, input logic [ADDR_W-1:0] a);
        if (wr || exp_err(wr, a)) return 32'd0;
        if (a[3:2] == 2'd1)
            return {20'd0, 4'(m_q.size()), 5'd0, m_busy, (m_q.size() == 0), (m_q.size() == DEPTH)};
        if (a[3:2] == 2'd2) return {16'd0, m_baud};
        if (a[3:2] == 2'd3) return {31'd0, m_en};
        return 32'd0;
    endfunction

    // Reference model: commits APB side effects and advances the frame timer.
    always @(posedge PCLK) begin : ref_model
        bit       acc, err, full_pre, ending, can_pop;
        bit [7:0] b;
        int       sel;
        if (!PRESETn) begin
            m_q.delete();
            m_en   = 1'b1;
            m_baud = 16'd867;
            m_busy = 1'b0;
            m_t    = 0;
        end else begin
            acc      = PSEL && PENABLE;
            sel      = int'(PADDR[3:2]);
            full_pre = (m_q.size() == DEPTH);
            ending   = m_busy && (m_t + 1 == 10 * (m_div + 1));
            can_pop  = (!m_busy || ending) && m_en && (m_q.size() != 0);
            err      = acc && (PADDR[4] || (PWRITE && sel == 0 && full_pre));
            if (m_busy) m_t++;
            if (ending) m_busy = 1'b0;
            if (can_pop) begin
                b      = m_q.pop_front();
                m_bits = {1'b1, b, 1'b0};
                m_div  = int'(m_baud);
                m_t    = 0;
                m_busy = 1'b1;
            end
            if (acc && PWRITE && !err) begin
                if (sel == 0)      m_q.push_back(PWDATA[7:0]);
                else if (sel == 2) m_baud = PWDATA[15:0];
                else if (sel == 3) m_en = PWDATA[0];
            end
        end
    end

    // Per-cycle monitor of the serial side and the idle bus response.
    always @(negedge PCLK) begin
        #2;
        check_eq("tx", {31'd0, tx}, {31'd0, exp_tx()});
        check_eq("tx_busy", {31'd0, tx_busy}, {31'd0, m_busy});
        check_eq("tx_full", {31'd0, tx_full}, {31'd0, (m_q.size() == DEPTH)});
        if (!(PSEL && PENABLE)) begin
            check_eq("idle_pready", {31'd0, PREADY}, 32'd0);
            check_eq("idle_prdata", PRDATA, 32'd0);
            check_eq("idle_pslverr", {31'd0, PSLVERR}, 32'd0);
        end
    end

    task automatic apb(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        @(negedge PCLK);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        rd  = PRDATA;
        err = PSLVERR;
        check_eq("pready", {31'd0, PREADY}, 32'd1);
        check_eq("pslverr", {31'd0, PSLVERR}, {31'd0, exp_err(wr, a)});
        check_eq("prdata", PRDATA, exp_rd(wr, a));
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while ((tx_busy !== 1'b0 || m_q.size() != 0) && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        check_eq(tag, {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin : stim
        logic [31:0] rd;
        logic        err;
        logic [9:0]  pat;
        logic [ADDR_W-1:0] a;
        logic [31:0] d;
        int          r;

        PRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = 32'd0;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;

        // reset state
        apb(1'b0, 5'h04, 32'd0, rd, err);
        check_eq("rst_status", rd, 32'h0000_0002);
        check_eq("rst_status_err", {31'd0, err}, 32'd0);
        apb(1'b0, 5'h08, 32'd0, rd, err);
        check_eq("rst_baud", rd, 32'd867);
        check_eq("rst_tx", {31'd0, tx}, 32'd1);

        // single frame 0xA5 at 4 cycles per bit
        apb(1'b1, 5'h08, 32'd3, rd, err);
        apb(1'b1, 5'h00, 32'h0000_00A5, rd, err);
        pat = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            #1;
            check_eq("a5_tx", {31'd0, tx}, {31'd0, pat[k / 4]});
            check_eq("a5_busy", {31'd0, tx_busy}, 32'd1);
        end
        @(negedge PCLK);
        #1;
        check_eq("a5_busy_end", {31'd0, tx_busy}, 32'd0);

        // fill with CTRL.en=0, overflow, then drain back-to-back
        apb(1'b1, 5'h0C, 32'd0, rd, err);
        for (int k = 0; k < DEPTH; k++) apb(1'b1, 5'h00, 32'(8'h10 + k), rd, err);
        check_eq("fill_full", {31'd0, tx_full}, 32'd1);
        apb(1'b0, 5'h04, 32'd0, rd, err);
        check_eq("fill_status", rd, 32'h0000_0801);
        apb(1'b1, 5'h00, 32'h0000_00EE, rd, err);
        check_eq("ovf_err", {31'd0, err}, 32'd1);
        apb(1'b1, 5'h0C, 32'd1, rd, err);
        wait_idle(DEPTH * 40 + 50, "drain_idle");

        // out-of-range addresses
        apb(1'b0, 5'h10, 32'd0, rd, err);
        check_eq("oor_rd_err", {31'd0, err}, 32'd1);
        check_eq("oor_rd_data", rd, 32'd0);
        apb(1'b1, 5'h14, 32'h0000_0007, rd, err);
        check_eq("oor_wr_err", {31'd0, err}, 32'd1);
        apb(1'b0, 5'h08, 32'd0, rd, err);
        check_eq("oor_baud_kept", rd, 32'd3);

        // reset in the middle of data bit 3
        apb(1'b1, 5'h00, 32'h0000_003C, rd, err);
        repeat (18) @(negedge PCLK);
        PRESETn = 1'b0;
        @(negedge PCLK);
        #1;
        check_eq("mid_rst_tx", {31'd0, tx}, 32'd1);
        check_eq("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        PRESETn = 1'b1;
        apb(1'b0, 5'h04, 32'd0, rd, err);
        check_eq("mid_rst_status", rd, 32'h0000_0002);
        apb(1'b0, 5'h08, 32'd0, rd, err);
        check_eq("mid_rst_baud", rd, 32'd867);

        // BAUDDIV change during a frame only affects the next one
        apb(1'b1, 5'h08, 32'd3, rd, err);
        apb(1'b1, 5'h00, 32'h0000_005A, rd, err);
        apb(1'b1, 5'h00, 32'h0000_00C3, rd, err);
        apb(1'b1, 5'h08, 32'h0000_0001, rd, err);
        wait_idle(200, "baud_chg_idle");

        // randomized traffic, BAUDDIV kept small
        apb(1'b1, 5'h08, 32'd2, rd, err);
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 9));
            a = {3'b000, 2'($urandom_range(0, 3))};
            d = $urandom();
            if (r <= 3) begin
                a[3:2] = 2'd0;
                apb(1'b1, a, d, rd, err);
            end else if (r == 4) begin
                a[3:2] = 2'd1;
                apb(1'(($urandom() & 32'd1)), a, d, rd, err);
            end else if (r == 5) begin
                a[3:2] = 2'd2;
                apb(1'b1, a, (d & 32'hFFFF_0000) | 32'($urandom_range(0, 3)), rd, err);
            end else if (r == 6) begin
                a[3:2] = 2'd2;
                apb(1'b0, a, d, rd, err);
            end else if (r == 7) begin
                a[3:2] = 2'd3;
                apb(1'b1, a, (d & 32'hFFFF_FFFE) | 32'($urandom_range(0, 3) != 0), rd, err);
            end else if (r == 8) begin
                a[3] = 1'b1;
                apb(1'b0, a, d, rd, err);
            end else begin
                a[4] = 1'b1;
                a[3:2] = 2'($urandom_range(0, 3));
                apb(1'(($urandom() & 32'd1)), a, d, rd, err);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) @(negedge PCLK);
        end
        apb(1'b1, 5'h0C, 32'd1, rd, err);
        wait_idle((DEPTH + 2) * 40 + 50, "rand_idle");

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
